entrada_bcd: RTL and testbench
==============================

// Module: entrada_bcd
// PURPOSE
//  Input-side peer of the 7-segment output stage: reads four BCD digit switch groups, converts them
//  to a 32-bit binary word and hands it to the MIPS datapath for the IN instruction.
//  User sets digits, presses confirma; block converts digit-serially (acc*10+d) and holds pronto
//  until the core consumes the word; stalls the core via espera while no word is ready.
// PARAMETERS
//  DIGITOS      4   number of BCD digits, MSD first (milhares..unidades)
//  LARGURA      32  width of valorentrada
//  SYNC_STAGES  2   flip-flops in the confirma synchronizer (>=2)
// PORTS
//  clock        in   1          system clock, all state on posedge
//  reset        in   1          synchronous, active-high
//  milhares     in   4          BCD digit 3 (switches, async to clock, sampled only at capture)
//  centenas     in   4          BCD digit 2
//  dezenas      in   4          BCD digit 1
//  unidades     in   4          BCD digit 0
//  confirma     in   1          push-button, asynchronous, active-high
//  in           in   1          core executing IN this cycle (consume request)
//  valorentrada out  LARGURA    converted value, registered
//  pronto       out  1          valorentrada valid and not yet consumed
//  espera       out  1          stall request to core: in & ~pronto (combinational)
//  erro         out  1          last capture had a digit > 9 (registered)
//  ocupado      out  1          conversion in progress
// BEHAVIOUR
//  Reset: state=OCIOSO; valorentrada=0, pronto=0, erro=0, ocupado=0; synchronizer flops=0.
//  confirma -> SYNC_STAGES-flop sync -> rising-edge detect -> 1-cycle pulse "cap".
//  FSM states: OCIOSO, CONV, PRONTO.
//   OCIOSO: cap & all digits<=9 -> snapshot digits, acc=0, idx=DIGITOS-1, erro=0 -> CONV.
//           cap & any digit>9   -> erro=1, stay OCIOSO, valorentrada/pronto unchanged.
//   CONV:   ocupado=1; acc <= acc*10 + dig[idx] (LARGURA-bit, zero-extended digits, no overflow
//           possible for DIGITOS<=9); idx decrements; after DIGITOS cycles ->
//           valorentrada<=acc_final, pronto<=1 -> PRONTO. cap ignored in CONV.
//   PRONTO: in -> pronto<=0 next edge, valorentrada held, -> OCIOSO. Core samples
//           valorentrada in the cycle in&pronto. cap (valid) -> new conversion, pronto<=0, -> CONV.
//  Latency: cap at edge T -> CONV during T+1..T+DIGITOS -> pronto=1 from edge T+DIGITOS+1.
//  Simultaneous in & valid cap in PRONTO: consume honoured this cycle and new conversion starts.
//  Simultaneous in & cap in OCIOSO: espera=1 this cycle; conversion starts.
//  Repeated reads need a new confirma; value 0 (all digits 0) is a legal word.
//  Reset mid-CONV: aborts, returns to reset values; no partial value ever reaches valorentrada.
//  Digit switches changing during CONV have no effect (snapshot).
// CONFIGURATION
//  ENTRADA_SINAL_EN defined: extra port negativo (in, 1, sign switch) snapshotted with digits;
//   if set, valorentrada = -acc (two's complement) on entry to PRONTO; -0 yields 0.
//  Not defined: port absent, valorentrada always unsigned, 0..10^DIGITOS-1.
// STRUCTURE
//  Package entrada_pkg: state enum (OCIOSO/CONV/PRONTO), BCD_MAX=4'd9, DIGITOS default,
//   function mul10(x) = (x<<3)+(x<<1).
//  Sub-module sincroniza_borda: SYNC_STAGES synchronizer + rising-edge pulse, reused for
//   other push-buttons on the board.
// TESTING
//  1. digits 1,2,3,4, pulse confirma -> pronto rises 5 cycles after cap, valorentrada=1234.
//  2. pronto=1, assert in 1 cycle -> pronto=0 next edge, valorentrada still 1234, state OCIOSO.
//  3. in=1 with no word -> espera=1 every cycle; then confirma 0,0,0,7 -> espera drops when pronto=1, value 7.
//  4. digits 9,A,0,0 + confirma -> erro=1, pronto/valorentrada unchanged; retry 9,9,9,9 -> 9999, erro=0.
//  5. change switches to 5,5,5,5 mid-CONV, second confirma mid-CONV -> result unaffected (snapshot, cap ignored).
//  6. reset at 2nd CONV cycle -> all outputs 0 next edge; ENTRADA_SINAL_EN build: negativo=1, 0,0,4,2 -> 32'hFFFFFFD6.

Source files
------------

// File: rtl/entrada_bcd_pkg.sv
// entrada_pkg: shared types and helpers for the BCD input stage.
//   estado_t      : conversion FSM states
//   BCD_MAX       : largest legal BCD digit
//   DIGITOS_PADRAO: default digit count
//   mul10()       : shift-add multiply by ten
package entrada_pkg;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    CONV   = 2'd1,
    PRONTO = 2'd2
  } estado_t;

  localparam logic [3:0]  BCD_MAX        = 4'd9;
  localparam int unsigned DIGITOS_PADRAO = 4;
  localparam int unsigned LARGURA_PADRAO = 32;
  localparam int unsigned DIG_W          = 4;
  localparam int unsigned MUL_W          = 64;

  // x*10 as (x<<3)+(x<<1); callers truncate to their own width.
  function automatic logic [MUL_W-1:0] mul10(input logic [MUL_W-1:0] x);
    return (x << 3) + (x << 1);
  endfunction

endpackage

// File: rtl/entrada_bcd_if.sv
// entrada_bcd_if: handshake between the BCD input stage and the MIPS core.
//   in           : core executes IN this cycle (consume request)
//   valorentrada : converted word
//   pronto       : word valid and not yet consumed
//   espera       : stall request to the core (in & ~pronto)
// Modports: master = core side, slave = input stage.
interface entrada_bcd_if #(
  parameter int unsigned LARGURA = 32
);
  logic               in;
  logic [LARGURA-1:0] valorentrada;
  logic               pronto;
  logic               espera;

  modport master (output in, input valorentrada, input pronto, input espera);
  modport slave  (input in, output valorentrada, output pronto, output espera);
endinterface

// File: rtl/entrada_bcd_sincroniza_borda.sv
// sincroniza_borda: SYNC_STAGES-flop synchronizer for an asynchronous
// push-button followed by a rising-edge detector; emits a registered
// one-cycle pulse per press.
//   clock, reset : system clock, synchronous active-high reset
//   botao_i      : asynchronous active-high button
//   pulso_o      : one-cycle pulse on each synchronized rising edge
module sincroniza_borda #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic botao_i,
  output logic pulso_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ant_q;
  logic                   pulso_q;

  // Synchronizer chain, previous-level flop and edge pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q  <= '0;
      ant_q   <= 1'b0;
      pulso_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], botao_i};
      ant_q   <= sync_q[SYNC_STAGES-1];
      pulso_q <= sync_q[SYNC_STAGES-1] & ~ant_q;
    end
  end

  assign pulso_o = pulso_q;

endmodule

// File: rtl/entrada_bcd.sv
// entrada_bcd: reads four BCD digit switch groups, converts them digit-serially
// (acc*10+d, most significant digit first) into a binary word and hands it to
// the core for the IN instruction.
//   clock, reset    : system clock, synchronous active-high reset
//   milhares..unidades : BCD digits 3..0 (snapshotted at capture)
//   negativo        : sign switch, only with ENTRADA_SINAL_EN defined
//   confirma        : asynchronous push-button starting a capture
//   cpu (slave)     : in / valorentrada / pronto / espera handshake
//   erro            : last capture contained a digit > 9
//   ocupado         : conversion in progress
// Optional feature: define ENTRADA_SINAL_EN for signed (negated) results.
module entrada_bcd
  import entrada_pkg::*;
#(
  parameter int unsigned DIGITOS     = DIGITOS_PADRAO,
  parameter int unsigned LARGURA     = LARGURA_PADRAO,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [DIG_W-1:0] milhares,
  input  logic [DIG_W-1:0] centenas,
  input  logic [DIG_W-1:0] dezenas,
  input  logic [DIG_W-1:0] unidades,
`ifdef ENTRADA_SINAL_EN
  input  logic             negativo,
`endif
  input  logic             confirma,
  entrada_bcd_if.slave     cpu,
  output logic             erro,
  output logic             ocupado
);

  localparam int unsigned IDX_W = (DIGITOS > 1) ? $clog2(DIGITOS) : 1;

  estado_t            estado_q;
  logic [LARGURA-1:0] acc_q;
  logic [LARGURA-1:0] acc_d;
  logic [LARGURA-1:0] final_c;
  logic [IDX_W-1:0]   idx_q;
  logic [LARGURA-1:0] valor_q;
  logic               pronto_q;
  logic               erro_q;
  logic               ocupado_q;
  logic               neg_q;
  logic [DIG_W-1:0]   dig_q  [DIGITOS];
  logic [DIG_W-1:0]   dig_sw [DIGITOS];
  logic [DIG_W-1:0]   portas [4];
  logic               cap;
  logic               valido_c;

  sincroniza_borda #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock   (clock),
    .reset   (reset),
    .botao_i (confirma),
    .pulso_o (cap)
  );

  // Switch groups as an array indexed by digit position (0 = unidades).
  assign portas = '{unidades, dezenas, centenas, milhares};

  for (genvar g = 0; g < DIGITOS; g++) begin : g_sw
    if (g < 4) begin : g_porta
      assign dig_sw[g] = portas[g];
    end else begin : g_zero
      assign dig_sw[g] = '0;
    end
  end

  // A capture is accepted only if every digit is a legal BCD value.
  always_comb begin
    valido_c = 1'b1;
    for (int i = 0; i < DIGITOS; i++) begin
      if (dig_sw[i] > BCD_MAX) valido_c = 1'b0;
    end
  end

  // One accumulation step on the snapshotted digit.
  assign acc_d = LARGURA'(mul10(MUL_W'(acc_q))) + LARGURA'(dig_q[idx_q]);

`ifdef ENTRADA_SINAL_EN
  // Two's complement negation; -0 naturally yields 0.
  assign final_c = neg_q ? LARGURA'(-acc_d) : acc_d;
`else
  assign final_c = acc_d;
`endif

  // Conversion FSM with registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q  <= OCIOSO;
      acc_q     <= '0;
      idx_q     <= '0;
      valor_q   <= '0;
      pronto_q  <= 1'b0;
      erro_q    <= 1'b0;
      ocupado_q <= 1'b0;
      neg_q     <= 1'b0;
      for (int i = 0; i < DIGITOS; i++) dig_q[i] <= '0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (cap) begin
            if (valido_c) begin
              dig_q     <= dig_sw;
              acc_q     <= '0;
              idx_q     <= IDX_W'(DIGITOS - 1);
              erro_q    <= 1'b0;
              ocupado_q <= 1'b1;
`ifdef ENTRADA_SINAL_EN
              neg_q     <= negativo;
`endif
              estado_q  <= CONV;
            end else begin
              erro_q <= 1'b1;
            end
          end
        end
        CONV: begin
          // Captures are ignored here; the snapshot stays frozen.
          acc_q <= acc_d;
          idx_q <= idx_q - IDX_W'(1);
          if (idx_q == '0) begin
            valor_q   <= final_c;
            pronto_q  <= 1'b1;
            ocupado_q <= 1'b0;
            estado_q  <= PRONTO;
          end
        end
        PRONTO: begin
          // The core samples valorentrada in the in&pronto cycle, so a
          // simultaneous valid capture both consumes and restarts.
          if (cap && valido_c) begin
            dig_q     <= dig_sw;
            acc_q     <= '0;
            idx_q     <= IDX_W'(DIGITOS - 1);
            erro_q    <= 1'b0;
            ocupado_q <= 1'b1;
            pronto_q  <= 1'b0;
`ifdef ENTRADA_SINAL_EN
            neg_q     <= negativo;
`endif
            estado_q  <= CONV;
          end else begin
            if (cap) erro_q <= 1'b1;
            if (cpu.in) begin
              pronto_q <= 1'b0;
              estado_q <= OCIOSO;
            end
          end
        end
        default: estado_q <= OCIOSO;
      endcase
    end
  end

  assign cpu.valorentrada = valor_q;
  assign cpu.pronto       = pronto_q;
  assign cpu.espera       = cpu.in & ~pronto_q;
  assign erro             = erro_q;
  assign ocupado          = ocupado_q;

endmodule

// File: tb/tb_entrada_bcd.sv
// tb_entrada_bcd: directed plus randomized checks of entrada_bcd against a
// decimal-arithmetic reference model.
module tb_entrada_bcd;

  localparam int unsigned DIGITOS     = 4;
  localparam int unsigned LARGURA     = 32;
  localparam int unsigned SYNC_STAGES = 2;
  // Edges from confirma sampled to pronto visible: sync + edge pulse + FSM entry + DIGITOS.
  localparam int unsigned LAT         = SYNC_STAGES + DIGITOS + 2;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] milhares, centenas, dezenas, unidades;
  logic       confirma;
  logic       erro, ocupado;
  bit         neg_sel;
`ifdef ENTRADA_SINAL_EN
  logic       negativo;
  assign negativo = neg_sel;
`endif

  entrada_bcd_if #(.LARGURA(LARGURA)) cpu ();

  entrada_bcd #(
    .DIGITOS(DIGITOS), .LARGURA(LARGURA), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .milhares (milhares),
    .centenas (centenas),
    .dezenas  (dezenas),
    .unidades (unidades),
`ifdef ENTRADA_SINAL_EN
    .negativo (negativo),
`endif
    .confirma (confirma),
    .cpu      (cpu),
    .erro     (erro),
    .ocupado  (ocupado)
  );

  always #5 clock = ~clock;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [31:0] valor_m;
  bit          pronto_m;
  bit          erro_m;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal value from the digits, optionally negated.
  function automatic logic [31:0] modelo(input int d3, input int d2, input int d1,
                                         input int d0, input bit neg);
    logic [31:0] r;
    r = 32'(d3 * 1000 + d2 * 100 + d1 * 10 + d0);
    if (neg) r = -r;
    return r;
  endfunction

  task automatic set_dig(input int a, input int b, input int c, input int d);
    milhares = 4'(a);
    centenas = 4'(b);
    dezenas  = 4'(c);
    unidades = 4'(d);
  endtask

  task automatic ciclo();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Press confirma for one edge and follow the conversion.
  // modo 1: second press and switch change mid-conversion
  // modo 2: in asserted together with the capture seen in PRONTO
  // modo 3: in held high, espera checked every cycle
  task automatic converte(input int modo, input bit espera_pronto,
                          output int lat, output int n_ocup);
    bit visto_baixo;
    lat = 0;
    n_ocup = 0;
    visto_baixo = 1'b0;
    confirma = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      ciclo();
      if (k == 1) confirma = 1'b0;
      if (modo == 1) begin
        if (k == 2) confirma = 1'b1;
        if (k == 4) set_dig(5, 5, 5, 5);
        if (k == 7) confirma = 1'b0;
      end
      if (modo == 2) begin
        if (k == 3) cpu.in = 1'b1;
        if (k == 4) begin
          cpu.in = 1'b0;
          check("in_cap_pronto_drop", 64'(cpu.pronto), 64'(0));
        end
      end
      if (modo == 3) check("espera_stall", 64'(cpu.espera), 64'(k < int'(LAT)));
      if (ocupado) n_ocup++;
      if (!cpu.pronto) visto_baixo = 1'b1;
      if (espera_pronto && cpu.pronto && visto_baixo) begin
        lat = k;
        break;
      end
      if (!espera_pronto && k == 12) break;
    end
  endtask

  task automatic consome();
    cpu.in = 1'b1;
    ciclo();
    cpu.in = 1'b0;
    pronto_m = 1'b0;
    check("consume_pronto", 64'(cpu.pronto), 64'(pronto_m));
    check("consume_hold", 64'(cpu.valorentrada), 64'(valor_m));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, noc;
    int d [4];
    bit ok;

    reset = 1'b1;
    confirma = 1'b0;
    cpu.in = 1'b0;
    neg_sel = 1'b0;
    set_dig(0, 0, 0, 0);
    ciclo();
    ciclo();
    reset = 1'b0;
    valor_m = '0; pronto_m = 1'b0; erro_m = 1'b0;
    check("rst_valor",   64'(cpu.valorentrada), 64'(valor_m));
    check("rst_pronto",  64'(cpu.pronto), 64'(0));
    check("rst_erro",    64'(erro), 64'(0));
    check("rst_ocupado", 64'(ocupado), 64'(0));
    check("rst_espera",  64'(cpu.espera), 64'(0));

    // 1234 with latency
    set_dig(1, 2, 3, 4);
    converte(0, 1'b1, lat, noc);
    valor_m = modelo(1, 2, 3, 4, 1'b0); pronto_m = 1'b1;
    check("t1_lat",     64'(lat), 64'(LAT));
    check("t1_valor",   64'(cpu.valorentrada), 64'(valor_m));
    check("t1_ocup_n",  64'(noc), 64'(DIGITOS));
    check("t1_ocupado", 64'(ocupado), 64'(0));
    check("t1_espera",  64'(cpu.espera), 64'(0));

    // consume: one in cycle
    cpu.in = 1'b1;
    check("t2_no_stall", 64'(cpu.espera), 64'(0));
    consome();

    // in with no word stalls, then 0007 arrives
    cpu.in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ciclo();
      check("t3_espera_idle", 64'(cpu.espera), 64'(1));
    end
    set_dig(0, 0, 0, 7);
    converte(3, 1'b1, lat, noc);
    valor_m = 32'd7;
    check("t3_lat",   64'(lat), 64'(LAT));
    check("t3_valor", 64'(cpu.valorentrada), 64'(valor_m));
    ciclo();
    cpu.in = 1'b0;
    pronto_m = 1'b0;
    check("t3_consumed", 64'(cpu.pronto), 64'(pronto_m));

    // invalid digit, then 9999
    set_dig(9, 10, 0, 0);
    converte(0, 1'b0, lat, noc);
    erro_m = 1'b1;
    check("t4_erro",   64'(erro), 64'(erro_m));
    check("t4_pronto", 64'(cpu.pronto), 64'(pronto_m));
    check("t4_valor",  64'(cpu.valorentrada), 64'(valor_m));
    check("t4_ocup_n", 64'(noc), 64'(0));
    set_dig(9, 9, 9, 9);
    converte(0, 1'b1, lat, noc);
    valor_m = 32'd9999; pronto_m = 1'b1; erro_m = 1'b0;
    check("t4_lat",    64'(lat), 64'(LAT));
    check("t4_valor2", 64'(cpu.valorentrada), 64'(valor_m));
    check("t4_erro2",  64'(erro), 64'(erro_m));

    // from PRONTO: restart, switches change and second press mid-conversion
    set_dig(1, 0, 0, 8);
    converte(1, 1'b1, lat, noc);
    valor_m = modelo(1, 0, 0, 8, 1'b0);
    check("t5_lat",    64'(lat), 64'(LAT));
    check("t5_valor",  64'(cpu.valorentrada), 64'(valor_m));
    check("t5_ocup_n", 64'(noc), 64'(DIGITOS));
    for (int i = 0; i < 6; i++) ciclo();
    check("t5_hold_pronto", 64'(cpu.pronto), 64'(1));
    check("t5_hold_valor",  64'(cpu.valorentrada), 64'(valor_m));

    // simultaneous in and valid capture in PRONTO
    set_dig(2, 0, 2, 5);
    converte(2, 1'b1, lat, noc);
    valor_m = modelo(2, 0, 2, 5, 1'b0);
    check("t7_lat",   64'(lat), 64'(LAT));
    check("t7_valor", 64'(cpu.valorentrada), 64'(valor_m));

`ifdef ENTRADA_SINAL_EN
    consome();
    neg_sel = 1'b1;
    set_dig(0, 0, 4, 2);
    converte(0, 1'b1, lat, noc);
    valor_m = modelo(0, 0, 4, 2, 1'b1);
    check("neg_valor", 64'(cpu.valorentrada), 64'(32'hFFFF_FFD6));
    check("neg_model", 64'(cpu.valorentrada), 64'(valor_m));
    set_dig(0, 0, 0, 0);
    converte(0, 1'b1, lat, noc);
    valor_m = 32'd0;
    check("neg_zero", 64'(cpu.valorentrada), 64'(valor_m));
    neg_sel = 1'b0;
`endif

    // randomized captures against the decimal model
    for (int it = 0; it < 16; it++) begin
      for (int j = 0; j < 4; j++) d[j] = int'($urandom_range(9));
      if ($urandom_range(7) == 0) d[$urandom_range(3)] = 10 + int'($urandom_range(5));
      ok = 1'b1;
      for (int j = 0; j < 4; j++) if (d[j] > 9) ok = 1'b0;
`ifdef ENTRADA_SINAL_EN
      neg_sel = bit'($urandom_range(1));
`endif
      if (pronto_m && (!ok || $urandom_range(1) == 1)) consome();
      set_dig(d[3], d[2], d[1], d[0]);
      converte(0, ok, lat, noc);
      if (ok) begin
        valor_m = modelo(d[3], d[2], d[1], d[0], neg_sel);
        pronto_m = 1'b1; erro_m = 1'b0;
        check("rnd_lat", 64'(lat), 64'(LAT));
      end else begin
        erro_m = 1'b1;
      end
      check("rnd_valor",  64'(cpu.valorentrada), 64'(valor_m));
      check("rnd_pronto", 64'(cpu.pronto), 64'(pronto_m));
      check("rnd_erro",   64'(erro), 64'(erro_m));
    end
    neg_sel = 1'b0;

    // reset in the second conversion cycle
    if (pronto_m) consome();
    set_dig(12, 0, 0, 0);
    converte(0, 1'b0, lat, noc);
    check("t6_erro_pre", 64'(erro), 64'(1));
    set_dig(3, 1, 4, 1);
    confirma = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      ciclo();
      if (k == 1) confirma = 1'b0;
    end
    check("t6_ocupado_pre", 64'(ocupado), 64'(1));
    reset = 1'b1;
    ciclo();
    valor_m = '0; pronto_m = 1'b0; erro_m = 1'b0;
    check("t6_valor",   64'(cpu.valorentrada), 64'(valor_m));
    check("t6_pronto",  64'(cpu.pronto), 64'(pronto_m));
    check("t6_erro",    64'(erro), 64'(erro_m));
    check("t6_ocupado", 64'(ocupado), 64'(0));
    reset = 1'b0;
    for (int i = 0; i < 10; i++) ciclo();
    check("t6_no_partial", 64'(cpu.pronto), 64'(0));
    check("t6_valor_idle", 64'(cpu.valorentrada), 64'(valor_m));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
